mdio_slave: RTL and testbench

- Clause-22 MDIO target: the responder end of the MDC/MDIO management bus that our PHY-delay configuration masters drive.
- Oversamples MDC and MDIO on the local clk. Decodes read and write frames addressed to its PHY address.
- Exposes a simple single-cycle register port to a local register bank. Drives read data back on MDIO through an output-enable.
- Used in bench models of our PHYs and in FPGA-to-FPGA management links.

---
 rtl/mdio_slave.sv | 214 +++++++++++++++++++++
 tb/tb_mdio_slave.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mdio_slave.sv
// rtl/mdio_slave.sv - Clause-22 MDIO target with oversampled MDC/MDIO and a single-cycle register port.
// Define MDIO_PRE_SUPPRESS_EN to accept preamble-suppressed frames after a completed frame to this PHY.
module mdio_slave #(
  parameter logic [4:0] PHYAD       = 5'b00001,
  parameter int         PRE_LEN     = 32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdo_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wdata,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_PRE, S_ST1, S_OP, S_ADDR, S_TA_R, S_RD, S_TA_W, S_WR, S_SKIP
  } state_t;

  localparam logic [5:0] PRE_LEN_C = 6'(PRE_LEN);
`ifdef MDIO_PRE_SUPPRESS_EN
  localparam bit SUPP_EN = 1'b1;
`else
  localparam bit SUPP_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] mdc_sync, mdi_sync;
  logic mdc_prev, mdc_edge, mdi_bit;

  state_t      state, state_nxt;
  logic [5:0]  pre_cnt, pre_cnt_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [15:0] shift, shift_nxt;
  logic        is_read, is_read_nxt;
  logic [4:0]  addr_nxt;
  logic [15:0] wdata_nxt;
  logic        wr_en_nxt, rd_en_nxt, rd_en_d;
  logic        mdo_nxt, oe_nxt;
  logic        supp_ok, frame_done, bad_frame;
  logic [9:0]  addr_word;

  assign mdc_edge  = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
  assign mdi_bit   = mdi_sync[SYNC_STAGES-1];
  assign addr_word = {shift[8:0], mdi_bit};
  assign busy      = (state != S_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync <= '0;
      mdi_sync <= '0;
      mdc_prev <= 1'b0;
    end else begin
      mdc_sync <= {mdc_sync[SYNC_STAGES-2:0], mdc};
      mdi_sync <= {mdi_sync[SYNC_STAGES-2:0], mdi};
      mdc_prev <= mdc_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PRE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      is_read   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      rd_en_d   <= 1'b0;
      mdo       <= 1'b0;
      mdo_oe    <= 1'b0;
      supp_ok   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      is_read   <= is_read_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      reg_wr_en <= wr_en_nxt;
      reg_rd_en <= rd_en_nxt;
      rd_en_d   <= reg_rd_en;
      mdo       <= mdo_nxt;
      mdo_oe    <= oe_nxt;
      if (bad_frame)
        supp_ok <= 1'b0;
      else if (SUPP_EN && frame_done)
        supp_ok <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    is_read_nxt = is_read;
    addr_nxt    = reg_addr;
    wdata_nxt   = reg_wdata;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    mdo_nxt     = mdo;
    oe_nxt      = mdo_oe;
    frame_done  = 1'b0;
    bad_frame   = 1'b0;

    // Register bank answers one clk after the read strobe; edges are far apart so no overlap.
    if (rd_en_d)
      shift_nxt = reg_rdata;

    if (mdc_edge) begin
      case (state)
        S_PRE: begin
          if (mdi_bit) begin
            if (pre_cnt != 6'd63)
              pre_cnt_nxt = pre_cnt + 6'd1;
          end else begin
            pre_cnt_nxt = '0;
            if (pre_cnt >= PRE_LEN_C || supp_ok)
              state_nxt = S_ST1;
          end
        end
        S_ST1: begin
          bit_cnt_nxt = '0;
          if (mdi_bit) begin
            state_nxt = S_OP;
          end else begin
            state_nxt = S_PRE;
            bad_frame = 1'b1;
          end
        end
        S_OP: begin
          if (bit_cnt == 5'd0) begin
            shift_nxt[0] = mdi_bit;
            bit_cnt_nxt  = 5'd1;
          end else if (shift[0] != mdi_bit) begin
            is_read_nxt = shift[0];
            bit_cnt_nxt = '0;
            state_nxt   = S_ADDR;
          end else begin
            state_nxt = S_PRE;
            bad_frame = 1'b1;
          end
        end
        S_ADDR: begin
          shift_nxt   = {shift[14:0], mdi_bit};
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd9) begin
            addr_nxt    = addr_word[4:0];
            bit_cnt_nxt = '0;
            if (addr_word[9:5] != PHYAD) begin
              state_nxt = S_SKIP;
            end else if (is_read) begin
              rd_en_nxt = 1'b1;
              state_nxt = S_TA_R;
            end else begin
              state_nxt = S_TA_W;
            end
          end
        end
        S_TA_R: begin
          oe_nxt      = 1'b1;
          mdo_nxt     = 1'b0;
          bit_cnt_nxt = '0;
          state_nxt   = S_RD;
        end
        S_RD: begin
          if (bit_cnt == 5'd16) begin
            oe_nxt     = 1'b0;
            mdo_nxt    = 1'b0;
            state_nxt  = S_PRE;
            frame_done = 1'b1;
          end else begin
            mdo_nxt     = shift[15];
            shift_nxt   = {shift[14:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        S_TA_W: begin
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_WR;
          end
        end
        S_WR: begin
          shift_nxt   = {shift[14:0], mdi_bit};
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            wdata_nxt  = {shift[14:0], mdi_bit};
            wr_en_nxt  = 1'b1;
            state_nxt  = S_PRE;
            frame_done = 1'b1;
          end
        end
        S_SKIP: begin
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd17)
            state_nxt = S_PRE;
        end
        default: state_nxt = S_PRE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// tb/tb_mdio_slave.sv - Directed self-checking bench for mdio_slave acting as an MDIO master.
module tb_mdio_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        mdi = 1'b1;
  logic        mdo, mdo_oe;
  logic [4:0]  reg_addr;
  logic        reg_wr_en, reg_rd_en, busy;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = 16'hBEEF;
  logic [15:0] rd_value = 16'h1234;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
  logic [4:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;

  mdio_slave dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdi(mdi),
    .mdo(mdo), .mdo_oe(mdo_oe), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register bank: data is valid only in the clk right after the read strobe.
  always @(posedge clk)
    reg_rdata <= reg_rd_en ? rd_value : 16'hBEEF;

  always @(negedge clk) begin
    if (mdo_oe) oe_cnt++;
    if (reg_wr_en) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
    if (reg_rd_en) begin rd_cnt++; rd_addr = reg_addr; end
  end

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; oe_cnt = 0;
  endtask

  task automatic mdio_cycle(input logic b, output logic s_mdo, output logic s_oe);
    mdi = b;
    mdc = 1'b0;
    repeat (5) @(negedge clk);
    s_mdo = mdo;
    s_oe  = mdo_oe;
    mdc = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic a, b;
    for (int i = n - 1; i >= 0; i--) mdio_cycle(v[i], a, b);
  endtask

  task automatic send_ones(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) mdio_cycle(1'b1, a, b);
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] ra, output logic [15:0] data,
                         output logic ta1_oe, output logic ta2_ok, output logic oe_all,
                         output logic oe_after);
    logic s_mdo, s_oe;
    send_ones(32);
    send_bits({18'd0, 2'b01, 2'b10, phy, ra}, 14);
    mdio_cycle(1'b1, s_mdo, s_oe); ta1_oe = s_oe;
    mdio_cycle(1'b1, s_mdo, s_oe); ta2_ok = s_oe & ~s_mdo;
    oe_all = 1'b1;
    data = '0;
    for (int i = 0; i < 16; i++) begin
      mdio_cycle(1'b1, s_mdo, s_oe);
      data = {data[14:0], s_mdo};
      oe_all = oe_all & s_oe;
    end
    mdio_cycle(1'b1, s_mdo, s_oe); oe_after = s_oe;
  endtask

  task automatic test_reset();
    checks++; if (mdo !== 1'b0) begin errors++; $display("FAIL reset_mdo got %b want 0", mdo); end
    checks++; if (mdo_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", mdo_oe); end
    checks++; if (reg_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h want 0", reg_addr); end
    checks++; if (reg_wdata !== 16'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", reg_wdata); end
    checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", reg_wr_en); end
    checks++; if (reg_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", reg_rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_write();
    clear_mon();
    send_ones(32);
    send_bits({18'd0, 2'b01, 2'b01, 5'd1, 5'd3}, 14);
    send_bits({14'd0, 2'b10, 16'hA5C3}, 18);
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL write_count got %0d want 1", wr_cnt); end
    checks++; if (wr_addr !== 5'd3) begin errors++; $display("FAIL write_addr got %0d want 3", wr_addr); end
    checks++; if (wr_data !== 16'hA5C3) begin errors++; $display("FAIL write_data got %h want a5c3", wr_data); end
    checks++; if (oe_cnt !== 0) begin errors++; $display("FAIL write_oe got %0d clks want 0", oe_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic [15:0] d;
    logic t1, t2, oa, of;
    clear_mon();
    rd_value = 16'h1234;
    do_read(5'd1, 5'd7, d, t1, t2, oa, of);
    checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL read_count got %0d want 1", rd_cnt); end
    checks++; if (rd_addr !== 5'd7) begin errors++; $display("FAIL read_addr got %0d want 7", rd_addr); end
    checks++; if (t1 !== 1'b0) begin errors++; $display("FAIL read_ta1_oe got %b want 0", t1); end
    checks++; if (t2 !== 1'b1) begin errors++; $display("FAIL read_ta2_zero got %b want 1", t2); end
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL read_data got %h want 1234", d); end
    checks++; if (oa !== 1'b1) begin errors++; $display("FAIL read_oe_data got %b want 1", oa); end
    checks++; if (of !== 1'b0) begin errors++; $display("FAIL read_oe_release got %b want 0", of); end
  endtask

  task automatic test_mismatch();
    clear_mon();
    send_ones(32);
    send_bits({18'd0, 2'b01, 2'b01, 5'd2, 5'd3}, 14);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mis_wr_busy got %b want 1", busy); end
    send_bits({14'd0, 2'b10, 16'hFFFF}, 18);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mis_wr_busy_end got %b want 0", busy); end
    send_ones(32);
    send_bits({18'd0, 2'b01, 2'b10, 5'd2, 5'd7}, 14);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mis_rd_busy got %b want 1", busy); end
    send_ones(18);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mis_rd_busy_end got %b want 0", busy); end
    checks++; if (wr_cnt + rd_cnt !== 0) begin errors++; $display("FAIL mis_strobes got %0d want 0", wr_cnt + rd_cnt); end
    checks++; if (oe_cnt !== 0) begin errors++; $display("FAIL mis_oe got %0d clks want 0", oe_cnt); end
  endtask

  task automatic test_short_preamble();
    clear_mon();
    send_ones(31);
    send_bits({18'd0, 2'b01, 2'b01, 5'd1, 5'd5}, 14);
    send_bits({14'd0, 2'b10, 16'h0F0F}, 18);
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL short_pre_count got %0d want 0", wr_cnt); end
    send_ones(32);
    send_bits({18'd0, 2'b01, 2'b01, 5'd1, 5'd5}, 14);
    send_bits({14'd0, 2'b10, 16'h0F0F}, 18);
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL full_pre_count got %0d want 1", wr_cnt); end
    checks++; if (wr_data !== 16'h0F0F || wr_addr !== 5'd5) begin
      errors++; $display("FAIL full_pre_data got %h@%0d want 0f0f@5", wr_data, wr_addr);
    end
  endtask

  task automatic test_bad_opcode();
    clear_mon();
    send_ones(32);
    send_bits({28'd0, 2'b01, 2'b00}, 4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badop_busy got %b want 0", busy); end
    send_bits({22'd0, 5'd1, 5'd4}, 10);
    send_bits({14'd0, 2'b10, 16'h1111}, 18);
    checks++; if (wr_cnt + rd_cnt !== 0) begin errors++; $display("FAIL badop_strobes got %0d want 0", wr_cnt + rd_cnt); end
    send_ones(32);
    send_bits({18'd0, 2'b01, 2'b01, 5'd1, 5'd4}, 14);
    send_bits({14'd0, 2'b10, 16'h5A5A}, 18);
    checks++; if (wr_cnt !== 1 || wr_data !== 16'h5A5A) begin
      errors++; $display("FAIL badop_recover got %0d/%h want 1/5a5a", wr_cnt, wr_data);
    end
  endtask

  task automatic test_reset_mid_read();
    logic s_mdo, s_oe, t1, t2, oa, of;
    logic [15:0] d;
    clear_mon();
    rd_value = 16'h8001;
    send_ones(32);
    send_bits({18'd0, 2'b01, 2'b10, 5'd1, 5'd9}, 14);
    for (int i = 0; i < 10; i++) mdio_cycle(1'b1, s_mdo, s_oe);
    checks++; if (mdo_oe !== 1'b1) begin errors++; $display("FAIL midrd_oe_before got %b want 1", mdo_oe); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mdo_oe !== 1'b0) begin errors++; $display("FAIL midrd_oe_async got %b want 0", mdo_oe); end
    checks++; if ({mdo, reg_addr, reg_wr_en, reg_rd_en, reg_wdata, busy} !== 25'd0) begin
      errors++; $display("FAIL midrd_outputs got mdo=%b addr=%h busy=%b want all 0", mdo, reg_addr, busy);
    end
    mdc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    do_read(5'd1, 5'd9, d, t1, t2, oa, of);
    checks++; if (rd_cnt !== 1 || rd_addr !== 5'd9) begin
      errors++; $display("FAIL midrd_next_strobe got %0d@%0d want 1@9", rd_cnt, rd_addr);
    end
    checks++; if (d !== 16'h8001 || t2 !== 1'b1) begin
      errors++; $display("FAIL midrd_next_data got %h ta=%b want 8001 ta=1", d, t2);
    end
    checks++; if (of !== 1'b0) begin errors++; $display("FAIL midrd_next_release got %b want 0", of); end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_write();
    test_read();
    test_mismatch();
    test_short_preamble();
    test_bad_opcode();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
